// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB skid stage: FSM states, load funct3 codes and
// the payload carried by each of the two buffer entries.
package mem_wb_pkg;

    localparam int PL_XLEN = 32;
    localparam int PL_RD_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic                   mem_to_reg;
        logic                   reg_write;
        logic [PL_RD_W-1:0]     rd;
        logic [PL_XLEN-1:0]     alu_result;
        logic [PL_XLEN-1:0]     mem_data;
    } wb_payload_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational RV32 load lane select and sign/zero extension applied to the
// raw memory word before it is captured by the skid stage.
module wb_load_align
    import mem_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      load_type,
    output logic [XLEN-1:0] mem_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        // Halfword lane uses addr[1] only; a misaligned addr[0] is ignored.
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];

        case (load_type)
            LB:      mem_data = {{(XLEN-8){lane_b[7]}}, lane_b};
            LBU:     mem_data = {{(XLEN-8){1'b0}}, lane_b};
            LH:      mem_data = {{(XLEN-16){lane_h[15]}}, lane_h};
            LHU:     mem_data = {{(XLEN-16){1'b0}}, lane_h};
            default: mem_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid
// buffer; in_ready is a pure function of state so out_ready never reaches it.
module mem_wb_skid_stage
    import mem_wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mem_to_reg,
    input  logic            in_reg_write,
    input  logic [RD_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [2:0]      in_load_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_reg_write,
    output logic [RD_W-1:0] out_rd,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_mem_data,
    output logic [XLEN-1:0] out_wb_data
);

    skid_state_e state_p1;
    skid_state_e state_nxt;
    wb_payload_t main_p1;
    wb_payload_t skid_p1;
    wb_payload_t in_pl_p0;
    logic [XLEN-1:0] ext_data_p0;

    logic accept;
    logic consume;
    logic load_main;
    logic load_skid;
    logic main_from_skid;

    // Stage p0: extend load data and form the incoming payload.
    wb_load_align #(.XLEN(XLEN)) u_align (
        .rdata     (in_mem_rdata),
        .addr      (in_alu_result[1:0]),
        .load_type (in_load_type),
        .mem_data  (ext_data_p0)
    );

    always_comb begin
        in_pl_p0            = '0;
        in_pl_p0.mem_to_reg = in_mem_to_reg;
        in_pl_p0.reg_write  = in_reg_write && (in_rd != '0);
        in_pl_p0.rd         = in_rd;
        in_pl_p0.alu_result = in_alu_result;
        in_pl_p0.mem_data   = ext_data_p0;
    end

    assign in_ready  = (state_p1 != FULL);
    assign out_valid = (state_p1 != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_nxt      = state_p1;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_p1)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = MAIN;
                end
            end
            MAIN: begin
                if (accept && consume) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (consume) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    main_from_skid = 1'b1;
                    state_nxt      = MAIN;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt      = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // Stage p1: state and both payload entries; outputs must read zero after
    // reset and flush, so payload is cleared along with control.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_p1 <= EMPTY;
            main_p1  <= '0;
            skid_p1  <= '0;
        end else begin
            state_p1 <= state_nxt;
            if (flush) begin
                main_p1 <= '0;
                skid_p1 <= '0;
            end else begin
                if (load_main) begin
                    main_p1 <= in_pl_p0;
                end else if (main_from_skid) begin
                    main_p1 <= skid_p1;
                end
                if (load_skid) begin
                    skid_p1 <= in_pl_p0;
                end
            end
        end
    end

    assign out_reg_write  = out_valid && main_p1.reg_write;
    assign out_rd         = main_p1.rd;
    assign out_alu_result = main_p1.alu_result;
    assign out_mem_data   = main_p1.mem_data;
    assign out_wb_data    = main_p1.mem_to_reg ? main_p1.mem_data : main_p1.alu_result;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage: table of load vectors plus
// hand-written stream, backpressure, flush and reset sequences.
module tb_mem_wb_skid_stage;

    logic        clock;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_mem_to_reg;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [2:0]  in_load_type;
    logic        out_valid;
    logic        out_ready;
    logic        out_reg_write;
    logic [4:0]  out_rd;
    logic [31:0] out_alu_result;
    logic [31:0] out_mem_data;
    logic [31:0] out_wb_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wb;
        logic        regw;
        logic [31:0] alu;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] exp_wb;
        logic        exp_regw;
    } vec_t;

    mem_wb_skid_stage #(.XLEN(32), .RD_W(5)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_reg_write   (in_reg_write),
        .in_rd          (in_rd),
        .in_alu_result  (in_alu_result),
        .in_mem_rdata   (in_mem_rdata),
        .in_load_type   (in_load_type),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_reg_write  (out_reg_write),
        .out_rd         (out_rd),
        .out_alu_result (out_alu_result),
        .out_mem_data   (out_mem_data),
        .out_wb_data    (out_wb_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ext_model(logic [31:0] w, logic [1:0] a, logic [2:0] lt);
        logic [31:0] sh;
        case (lt)
            3'b000: begin sh = w >> {a, 3'b000};     return {{24{sh[7]}}, sh[7:0]};   end
            3'b100: begin sh = w >> {a, 3'b000};     return {24'h0, sh[7:0]};         end
            3'b001: begin sh = w >> {a[1], 4'b0000}; return {{16{sh[15]}}, sh[15:0]}; end
            3'b101: begin sh = w >> {a[1], 4'b0000}; return {16'h0, sh[15:0]};       end
            default: return w;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m2r, input logic rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [2:0] lt);
        in_valid      = 1'b1;
        in_mem_to_reg = m2r;
        in_reg_write  = rw;
        in_rd         = rd;
        in_alu_result = alu;
        in_mem_rdata  = rdata;
        in_load_type  = lt;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_mem_to_reg = 1'b0;
        in_reg_write  = 1'b0;
        in_rd         = '0;
        in_alu_result = '0;
        in_mem_rdata  = '0;
        in_load_type  = 3'b010;
    endtask

    // Scoreboard pop/push happens just before the edge, then inputs settle #1 after it.
    task automatic tick();
        exp_t e;
        exp_t n;
        logic [31:0] md;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got rd=%0d expected no entry", out_rd);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rd", {27'h0, out_rd}, {27'h0, e.rd});
                    chk("sb_wb_data", out_wb_data, e.wb);
                    chk("sb_reg_write", {31'h0, out_reg_write}, {31'h0, e.regw});
                    chk("sb_alu", out_alu_result, e.alu);
                end
            end
            if (in_valid && in_ready) begin
                md     = ext_model(in_mem_rdata, in_alu_result[1:0], in_load_type);
                n.rd   = in_rd;
                n.alu  = in_alu_result;
                n.wb   = in_mem_to_reg ? md : in_alu_result;
                n.regw = in_reg_write && (in_rd != 5'd0);
                sb.push_back(n);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 12 && sb.size() != 0; k++) tick();
        chk(name, sb.size(), 0);
    endtask

    vec_t vecs[11];
    logic acc;
    logic [31:0] wb_a;

    initial begin
        vecs[0]  = '{3'b000, 32'h0,    32'h80F1_7F82, 1'b1, 1'b1, 5'd3, 32'hFFFF_FF82, 1'b1};
        vecs[1]  = '{3'b100, 32'h1,    32'h80F1_7F82, 1'b1, 1'b1, 5'd4, 32'h0000_007F, 1'b1};
        vecs[2]  = '{3'b001, 32'h2,    32'h80F1_7F82, 1'b1, 1'b1, 5'd5, 32'hFFFF_80F1, 1'b1};
        vecs[3]  = '{3'b101, 32'h2,    32'h80F1_7F82, 1'b1, 1'b1, 5'd6, 32'h0000_80F1, 1'b1};
        vecs[4]  = '{3'b010, 32'h0,    32'h80F1_7F82, 1'b1, 1'b1, 5'd7, 32'h80F1_7F82, 1'b1};
        vecs[5]  = '{3'b000, 32'h3,    32'h80F1_7F82, 1'b1, 1'b1, 5'd8, 32'hFFFF_FF80, 1'b1};
        vecs[6]  = '{3'b100, 32'h2,    32'h80F1_7F82, 1'b1, 1'b0, 5'd9, 32'h0000_00F1, 1'b0};
        vecs[7]  = '{3'b001, 32'h3,    32'h80F1_7F82, 1'b1, 1'b1, 5'd10, 32'hFFFF_80F1, 1'b1};
        vecs[8]  = '{3'b101, 32'h1,    32'h80F1_7F82, 1'b1, 1'b1, 5'd11, 32'h0000_7F82, 1'b1};
        vecs[9]  = '{3'b010, 32'h0,    32'h1234_5678, 1'b1, 1'b1, 5'd0, 32'h1234_5678, 1'b0};
        vecs[10] = '{3'b010, 32'h1234, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd12, 32'h0000_1234, 1'b1};

        resetn    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_wb_data", out_wb_data, 32'h0);
        chk("rst_reg_write", {31'h0, out_reg_write}, 32'h0);
        chk("rst_rd", {27'h0, out_rd}, 32'h0);
        #3 resetn = 1'b1;
        @(posedge clock);
        #1;

        // Streaming at full throughput: each entry visible one cycle after accept.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'(i * 4), $urandom, 3'b010);
            tick();
            chk("stream_valid", {31'h0, out_valid}, 32'h1);
            chk("stream_rd", {27'h0, out_rd}, 32'(i));
        end
        idle();
        drain("stream_drained");

        // Backpressure: three offers with out_ready low.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd13, 32'h100, 32'hA5A5_0001, 3'b010);
        tick();
        drive(1'b1, 1'b1, 5'd14, 32'h104, 32'hA5A5_0002, 3'b010);
        tick();
        drive(1'b1, 1'b1, 5'd15, 32'h108, 32'hA5A5_0003, 3'b010);
        chk("bp_in_ready_full", {31'h0, in_ready}, 32'h0);
        wb_a = out_wb_data;
        tick();
        tick();
        chk("bp_hold_rd", {27'h0, out_rd}, 32'd13);
        chk("bp_hold_wb", out_wb_data, 32'hA5A5_0001);
        chk("bp_stable", out_wb_data, wb_a);
        chk("bp_still_full", {31'h0, in_ready}, 32'h0);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            acc = in_valid && in_ready;
            tick();
        end
        chk("bp_c_accepted", {31'h0, acc}, 32'h1);
        idle();
        drain("bp_drained");

        // Table-driven load extension and reg_write gating.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].m2r, vecs[i].rw, vecs[i].rd, vecs[i].alu, vecs[i].rdata, vecs[i].lt);
            tick();
            idle();
            chk("vec_valid", {31'h0, out_valid}, 32'h1);
            chk($sformatf("vec%0d_wb", i), out_wb_data, vecs[i].exp_wb);
            chk($sformatf("vec%0d_regw", i), {31'h0, out_reg_write}, {31'h0, vecs[i].exp_regw});
            tick();
        end
        drain("vec_drained");

        // Flush while FULL with a new entry offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd20, 32'h200, 32'h1111_1111, 3'b010);
        tick();
        drive(1'b1, 1'b1, 5'd21, 32'h204, 32'h2222_2222, 3'b010);
        tick();
        chk("fl_full", {31'h0, in_ready}, 32'h0);
        drive(1'b1, 1'b1, 5'd22, 32'h208, 32'h3333_3333, 3'b010);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("fl_out_valid", {31'h0, out_valid}, 32'h0);
        chk("fl_in_ready", {31'h0, in_ready}, 32'h1);
        chk("fl_reg_write", {31'h0, out_reg_write}, 32'h0);
        chk("fl_wb_zero", out_wb_data, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fl_no_out", {31'h0, out_valid}, 32'h0);
        end

        // Flush from EMPTY discards the entry accepted in that cycle.
        drive(1'b1, 1'b1, 5'd23, 32'h300, 32'h4444_4444, 3'b010);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("fl_empty_discard", {31'h0, out_valid}, 32'h0);
        tick();

        // Asynchronous reset asserted while FULL.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd24, 32'h400, 32'h5555_5555, 3'b010);
        tick();
        drive(1'b1, 1'b1, 5'd25, 32'h404, 32'h6666_6666, 3'b010);
        tick();
        idle();
        chk("rf_full", {31'h0, in_ready}, 32'h0);
        #2 resetn = 1'b0;
        #1;
        sb.delete();
        chk("rf_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rf_reg_write", {31'h0, out_reg_write}, 32'h0);
        chk("rf_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clock);
        #3 resetn = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("rf_after_valid", {31'h0, out_valid}, 32'h0);
        chk("rf_after_wb", out_wb_data, 32'h0);

        // Stage still functional after reset.
        drive(1'b0, 1'b1, 5'd26, 32'h0000_1234, 32'h0, 3'b010);
        tick();
        idle();
        chk("post_rst_wb", out_wb_data, 32'h0000_1234);
        drain("post_rst_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
